inv_key_schedule_buffer: RTL and testbench

- Consumer end of the round-key handshake (key_ready / round_key_needed) driven by the forward round-key generator.
- Collects all NR+1 round keys of one AES key schedule into a local store.
- Serves them to the decipher datapath in reverse order (round NR down to 0) over a valid/ack handshake.
- Supports replay of the stored schedule for further blocks without regenerating it.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/key_store_rf.sv | 25 ++
 rtl/inv_key_schedule_buffer.sv | 124 ++++++++++++
 tb/tb_inv_key_schedule_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round-key buffering logic.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_LOW = 2'd2,
    SERVE    = 2'd3
  } ksb_state_e;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Round-index width needed to address NR+1 round keys.
  function automatic int rw_of(input int nr);
    return $clog2(nr + 1);
  endfunction

endpackage

// File: rtl/key_store_rf.sv
// Round-key register file: one synchronous write port, one asynchronous
// read port. Storage is deliberately not reset.
module key_store_rf #(
  parameter int KW    = 128,
  parameter int DEPTH = 11,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [KW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [KW-1:0] rdata_o
);

  logic [KW-1:0] mem_q [DEPTH];

  // Capture a round key into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inv_key_schedule_buffer.sv
// Collects a full forward key schedule from the round-key generator and
// replays it to the decipher datapath in reverse round order.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing in flight; start collects, replay re-serves store
// COLLECT  | waiting for key_ready to capture slot wr_idx
// WAIT_LOW | key consumed; waiting for generator to drop key_ready
// SERVE    | presenting store[rd_idx] to the decipher, NR down to 0
module inv_key_schedule_buffer
  import aes_pkg::*;
#(
  parameter int KW = 128,
  parameter int NR = NR_128,
  parameter int RW = rw_of(NR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          replay,
  input  logic          key_ready,
  input  logic [KW-1:0] rkey,
  output logic          round_key_needed,
  output logic          dk_valid,
  output logic [KW-1:0] dk_key,
  output logic [RW-1:0] dk_round,
  output logic          dk_last,
  input  logic          dk_ack,
  output logic          loaded,
  output logic          busy
);

  localparam logic [RW-1:0] LAST_IDX = RW'(NR);

  ksb_state_e    state_q;
  logic [RW-1:0] wr_idx_q;
  logic [RW-1:0] rd_idx_q;
  logic          rkn_q;
  logic          dk_valid_q;
  logic          loaded_q;
  logic          store_we;
  logic [KW-1:0] store_rdata;

  // A key is written exactly once: only COLLECT captures, WAIT_LOW masks
  // the generator's lingering key_ready.
  assign store_we = (state_q == COLLECT) && key_ready;

  key_store_rf #(
    .KW    (KW),
    .DEPTH (NR + 1),
    .AW    (RW)
  ) u_store (
    .clk     (clk),
    .we_i    (store_we),
    .waddr_i (wr_idx_q),
    .wdata_i (rkey),
    .raddr_i (rd_idx_q),
    .rdata_o (store_rdata)
  );

  // Sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      rkn_q      <= 1'b0;
      dk_valid_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      rkn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= COLLECT;
            loaded_q <= 1'b0;
            wr_idx_q <= '0;
          end else if (replay && loaded_q) begin
            state_q    <= SERVE;
            rd_idx_q   <= LAST_IDX;
            dk_valid_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (key_ready) begin
            if (wr_idx_q < LAST_IDX) begin
              rkn_q    <= 1'b1;
              wr_idx_q <= wr_idx_q + 1'b1;
              state_q  <= WAIT_LOW;
            end else begin
              loaded_q   <= 1'b1;
              rd_idx_q   <= LAST_IDX;
              dk_valid_q <= 1'b1;
              state_q    <= SERVE;
            end
          end
        end
        WAIT_LOW: begin
          if (!key_ready) state_q <= COLLECT;
        end
        SERVE: begin
          if (dk_ack) begin
            if (rd_idx_q != '0) begin
              rd_idx_q <= rd_idx_q - 1'b1;
            end else begin
              dk_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign round_key_needed = rkn_q;
  assign dk_valid         = dk_valid_q;
  assign dk_key           = dk_valid_q ? store_rdata : '0;
  assign dk_round         = rd_idx_q;
  assign dk_last          = dk_valid_q && (rd_idx_q == '0);
  assign loaded           = loaded_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_inv_key_schedule_buffer.sv
// Bench for inv_key_schedule_buffer: an AES-128 key-expansion generator
// model feeds the block, a queue scoreboard holds the expected reverse
// key sequence.
module tb_inv_key_schedule_buffer;
  import aes_pkg::*;

  localparam int KW = 128;
  localparam int NR = NR_128;
  localparam int RW = 4;

  typedef struct packed {
    logic [RW-1:0] rnd;
    logic [KW-1:0] key;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          replay = 1'b0;
  logic          key_ready = 1'b0;
  logic [KW-1:0] rkey = '0;
  logic          dk_ack = 1'b0;
  logic          round_key_needed;
  logic          dk_valid;
  logic [KW-1:0] dk_key;
  logic [RW-1:0] dk_round;
  logic          dk_last;
  logic          loaded;
  logic          busy;

  exp_t          sb_q[$];
  logic [KW-1:0] rk [NR+1];
  logic [7:0]    sbox [256];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            pulse_cnt = 0;
  int            dbl_cnt = 0;
  logic          rkn_prev = 1'b0;

  inv_key_schedule_buffer #(.KW(KW), .NR(NR), .RW(RW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .replay           (replay),
    .key_ready        (key_ready),
    .rkey             (rkey),
    .round_key_needed (round_key_needed),
    .dk_valid         (dk_valid),
    .dk_key           (dk_key),
    .dk_round         (dk_round),
    .dk_last          (dk_last),
    .dk_ack           (dk_ack),
    .loaded           (loaded),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts round_key_needed high cycles and back-to-back highs.
  always @(negedge clk) begin
    if (round_key_needed) pulse_cnt <= pulse_cnt + 1;
    if (round_key_needed && rkn_prev) dbl_cnt <= dbl_cnt + 1;
    rkn_prev <= round_key_needed;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_model();
    logic [7:0]   inv;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] key0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    key0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int i = 0; i < 4; i++) w[i] = key0[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Generator model: present key r, expect a one-cycle pulse after capture,
  // keep key_ready high for 'hold' extra cycles, drop it, present next key.
  task automatic run_collect(input int hold, input int stop_after);
    int p0;
    int d0;
    p0 = pulse_cnt;
    d0 = dbl_cnt;
    start = 1'b1;
    key_ready = 1'b1;
    rkey = rk[0];
    cycle();
    start = 1'b0;
    chk("busy_after_start", KW'(busy), KW'(1));
    for (int r = 0; r <= NR; r++) begin
      if (r == stop_after) return;
      rkey = rk[r];
      key_ready = 1'b1;
      cycle();
      sb_q.push_front(exp_t'({RW'(r), rk[r]}));
      if (r < NR) begin
        chk("rkn_pulse", KW'(round_key_needed), KW'(1));
        for (int h = 0; h < hold; h++) cycle();
        key_ready = 1'b0;
        cycle();
      end else begin
        key_ready = 1'b0;
        chk("dk_valid_latency", KW'(dk_valid), KW'(1));
        chk("loaded", KW'(loaded), KW'(1));
        chk("rkn_count", KW'(pulse_cnt - p0), KW'(NR));
        chk("rkn_width", KW'(dbl_cnt - d0), KW'(0));
      end
    end
  endtask

  // Decipher model: ack every cycle except a stall window at stall_round;
  // optionally hammers start/replay throughout.
  task automatic run_serve(input int stall_round, input int stall_len, input logic poke,
                           output int ncyc);
    int   stall;
    int   budget;
    exp_t e;
    stall = 0;
    budget = 200;
    ncyc = 0;
    while (sb_q.size() > 0 && budget > 0) begin
      budget--;
      ncyc++;
      e = sb_q[0];
      chk("dk_valid", KW'(dk_valid), KW'(1));
      chk("dk_round", KW'(dk_round), KW'(e.rnd));
      chk("dk_key", dk_key, e.key);
      chk("dk_last", KW'(dk_last), KW'(e.rnd == '0));
      if (e.rnd == RW'(1)) chk("slot1_const", dk_key, 128'ha0fafe1788542cb123a339392a6c7605);
      if (e.rnd == RW'(0)) chk("slot0_const", dk_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      if (e.rnd == RW'(stall_round) && stall < stall_len) begin
        dk_ack = 1'b0;
        stall++;
      end else begin
        dk_ack = 1'b1;
        void'(sb_q.pop_front());
      end
      start = poke;
      replay = poke;
      cycle();
    end
    dk_ack = 1'b0;
    start = 1'b0;
    replay = 1'b0;
    chk("serve_budget", KW'(sb_q.size()), KW'(0));
    chk("dk_valid_end", KW'(dk_valid), KW'(0));
    chk("busy_end", KW'(busy), KW'(0));
    cycle();
    chk("busy_idle", KW'(busy), KW'(0));
  endtask

  initial begin
    int n;
    int p;
    build_model();

    repeat (3) cycle();
    chk("rst_rkn", KW'(round_key_needed), KW'(0));
    chk("rst_dk_valid", KW'(dk_valid), KW'(0));
    chk("rst_dk_key", dk_key, KW'(0));
    chk("rst_dk_round", KW'(dk_round), KW'(0));
    chk("rst_dk_last", KW'(dk_last), KW'(0));
    chk("rst_loaded", KW'(loaded), KW'(0));
    chk("rst_busy", KW'(busy), KW'(0));
    rst_n = 1'b1;
    cycle();

    replay = 1'b1;
    cycle();
    replay = 1'b0;
    chk("replay_unloaded_busy", KW'(busy), KW'(0));
    chk("replay_unloaded_valid", KW'(dk_valid), KW'(0));
    dk_ack = 1'b1;
    repeat (2) cycle();
    dk_ack = 1'b0;
    chk("idle_ack_busy", KW'(busy), KW'(0));

    run_collect(1, -1);
    chk("first_key_const", dk_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("first_round", KW'(dk_round), KW'(NR));
    run_serve(-1, 0, 1'b0, n);
    chk("b2b_cycles", KW'(n), KW'(NR + 1));

    p = pulse_cnt;
    for (int r = 0; r <= NR; r++) sb_q.push_front(exp_t'({RW'(r), rk[r]}));
    replay = 1'b1;
    cycle();
    replay = 1'b0;
    chk("replay_busy", KW'(busy), KW'(1));
    run_serve(6, 5, 1'b1, n);
    chk("stall_cycles", KW'(n), KW'(NR + 1 + 5));
    chk("replay_no_rkn", KW'(pulse_cnt - p), KW'(0));
    chk("replay_loaded", KW'(loaded), KW'(1));

    run_collect(3, -1);
    run_serve(-1, 0, 1'b0, n);

    run_collect(0, 4);
    key_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("midrst_busy", KW'(busy), KW'(0));
    chk("midrst_loaded", KW'(loaded), KW'(0));
    chk("midrst_rkn", KW'(round_key_needed), KW'(0));
    chk("midrst_dk_valid", KW'(dk_valid), KW'(0));
    rst_n = 1'b1;
    sb_q.delete();
    cycle();
    replay = 1'b1;
    cycle();
    replay = 1'b0;
    chk("midrst_replay_ignored", KW'(busy), KW'(0));

    run_collect(2, -1);
    run_serve(-1, 0, 1'b0, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
